dqs_idelay_scan: RTL and testbench

- Receive-side calibration engine for one DQS (or DQ) input lane.
- Steps the input delay tap from 0 upward through an idelay_pipe-style set/ld/delay interface.
- At each tap, samples the registered received strobe bit repeatedly and takes a majority vote. Finds the first tap where the majority value flips, then applies that tap.
- Runs in the clk_div domain, alongside the odelay_pipe-driven transmit path; used by the DQS loopback test and by memory read leveling.

---
 rtl/dqs_idelay_scan_pkg.sv | 42 ++++
 rtl/dqs_idelay_scan_sample_counter.sv | 87 ++++++++
 rtl/dqs_idelay_scan.sv | 193 +++++++++++++++++++
 tb/tb_dqs_idelay_scan.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dqs_idelay_scan_pkg.sv
// ---------------------------------------------------------------------------
// dqs_idelay_scan_pkg
// Shared definitions for the receive-side DQS delay scan engine:
//   - default parameter values for the scan engine and its sample counter
//   - the scan FSM state encoding
//   - clog2, used to size internal counters from parameters
// No ports; imported by dqs_idelay_scan and dqs_idelay_scan_sample_counter.
// ---------------------------------------------------------------------------
package dqs_idelay_scan_pkg;

  // Default tap width (32 taps), settle time after each apply, and
  // log2 of the number of samples taken per tap.
  localparam int DEF_DLY_WIDTH     = 5;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SAMPLE_LOG2   = 4;

  // Scan FSM states. LOAD/SET drive the idelay_pipe strobes for one tap,
  // SETTLE/SAMPLE wait and accumulate, EVAL decides, APPLY/FINISH load
  // the chosen tap and report completion.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SET,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_APPLY,
    ST_FINISH
  } scanState_e;

  // Smallest width able to hold the values 0..value-1.
  // Returns 0 for value <= 1; callers always pass at least 2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dqs_idelay_scan_sample_counter.sv
// ---------------------------------------------------------------------------
// dqs_idelay_scan_sample_counter
// Per-tap timing and vote accumulator for the DQS delay scan.
// After a clear, every cycle with run_i high advances one internal cycle
// counter. The first SETTLE_CYCLES run cycles are discarded (the delay line
// is still settling); the next 2^SAMPLE_LOG2 run cycles add sample_i into
// the ones counter.
//
// Ports:
//   clk_i       scan clock
//   rst_i       synchronous active-high reset
//   clr_i       synchronous clear of the cycle and ones counters
//   run_i       advance one cycle (high while the scan settles or samples)
//   sample_i    registered received strobe bit
//   ones_o      number of ones seen in the sample window
//   settled_o   high on the last settle cycle
//   finished_o  high on the last sample cycle
// ---------------------------------------------------------------------------
module dqs_idelay_scan_sample_counter
  import dqs_idelay_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_LOG2   = DEF_SAMPLE_LOG2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   run_i,
  input  logic                   sample_i,
  output logic [SAMPLE_LOG2:0]   ones_o,
  output logic                   settled_o,
  output logic                   finished_o
);

  localparam int NUM_SAMPLES = 2 ** SAMPLE_LOG2;
  localparam int CNT_W       = clog2(SETTLE_CYCLES + NUM_SAMPLES);

  localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_FIRST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST  = CNT_W'(SETTLE_CYCLES + NUM_SAMPLES - 1);
  localparam logic [SAMPLE_LOG2:0] ONES_MAX     = (SAMPLE_LOG2 + 1)'(NUM_SAMPLES);

  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [SAMPLE_LOG2:0] ones_q;
  logic [SAMPLE_LOG2:0] ones_d;
  logic                 inWindow;

  // Samples only count once the settle phase is over.
  assign inWindow = (count_q >= SAMPLE_FIRST);

  // Next-state logic for the cycle counter and the ones accumulator.
  // The cycle counter parks on the last sample cycle so it can never wrap
  // back into the settle window, and the ones counter saturates at the
  // sample count so a stray extra run cycle cannot overflow it.
  always_comb begin
    count_d = count_q;
    ones_d  = ones_q;
    if (clr_i) begin
      count_d = '0;
      ones_d  = '0;
    end else if (run_i) begin
      if (count_q != SAMPLE_LAST) begin
        count_d = count_q + CNT_W'(1);
      end
      if (inWindow && sample_i && (ones_q != ONES_MAX)) begin
        ones_d = ones_q + (SAMPLE_LOG2 + 1)'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      ones_q  <= '0;
    end else begin
      count_q <= count_d;
      ones_q  <= ones_d;
    end
  end

  assign ones_o     = ones_q;
  assign settled_o  = run_i && (count_q == SETTLE_LAST);
  assign finished_o = run_i && (count_q == SAMPLE_LAST);

endmodule

// File: rtl/dqs_idelay_scan.sv
// ---------------------------------------------------------------------------
// dqs_idelay_scan
// Receive-side calibration engine for one DQS/DQ input lane. Steps the
// idelay tap upward from 0, takes a majority vote of the received strobe
// at each tap, stops at the first tap whose vote differs from the previous
// tap's vote and loads that tap (or tap 0 when no flip is seen).
//
// Ports:
//   clk         scan clock (clk_div domain)
//   rst         synchronous active-high reset
//   start       one-cycle scan request, honoured only when idle
//   dqs_sample  received strobe bit, already registered in this domain
//   delay       tap value presented to the idelay_pipe
//   ld          one-cycle load strobe for delay
//   set         one-cycle apply strobe, one cycle after ld
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse at the end of a scan
//   edge_found  a vote flip was found in the last scan
//   edge_tap    first tap whose vote differs from the previous tap, else 0
//   edge_pol    vote value after the flip, else 0
// ---------------------------------------------------------------------------
module dqs_idelay_scan
  import dqs_idelay_scan_pkg::*;
#(
  parameter int DLY_WIDTH     = DEF_DLY_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_LOG2   = DEF_SAMPLE_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dqs_sample,
  output logic [DLY_WIDTH-1:0] delay,
  output logic                 ld,
  output logic                 set,
  output logic                 busy,
  output logic                 done,
  output logic                 edge_found,
  output logic [DLY_WIDTH-1:0] edge_tap,
  output logic                 edge_pol
);

  localparam logic [DLY_WIDTH-1:0]   TAP_MAX = '1;
  localparam logic [SAMPLE_LOG2:0]   HALF    = (SAMPLE_LOG2 + 1)'(2 ** (SAMPLE_LOG2 - 1));

  scanState_e           state_q;
  logic [DLY_WIDTH-1:0] tap_q;
  logic                 havePrev_q;
  logic                 prevMaj_q;
  logic [DLY_WIDTH-1:0] delay_q;
  logic                 ld_q;
  logic                 set_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 edgeFound_q;
  logic [DLY_WIDTH-1:0] edgeTap_q;
  logic                 edgePol_q;

  logic                 cntClr;
  logic                 cntRun;
  logic [SAMPLE_LOG2:0] ones;
  logic                 settled;
  logic                 finished;
  logic                 maj;

  // The counter is cleared while the set strobe is out, so it starts
  // counting settle cycles on the first cycle after the new tap is applied.
  assign cntClr = (state_q == ST_SET);
  assign cntRun = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

  dqs_idelay_scan_sample_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_LOG2   (SAMPLE_LOG2)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (cntClr),
    .run_i      (cntRun),
    .sample_i   (dqs_sample),
    .ones_o     (ones),
    .settled_o  (settled),
    .finished_o (finished)
  );

  // Strict majority: exactly half ones is a tie and votes 0.
  assign maj = (ones > HALF);

  // Scan sequencer. All outputs are registered here: each strobe is set on
  // the transition into the state that owns it and cleared by the default
  // at the top, so ld/set/done are single-cycle pulses. delay only changes
  // together with ld, so it stays stable between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      havePrev_q  <= 1'b0;
      prevMaj_q   <= 1'b0;
      delay_q     <= '0;
      ld_q        <= 1'b0;
      set_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      edgeFound_q <= 1'b0;
      edgeTap_q   <= '0;
      edgePol_q   <= 1'b0;
    end else begin
      ld_q   <= 1'b0;
      set_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            tap_q       <= '0;
            havePrev_q  <= 1'b0;
            prevMaj_q   <= 1'b0;
            edgeFound_q <= 1'b0;
            edgeTap_q   <= '0;
            edgePol_q   <= 1'b0;
            busy_q      <= 1'b1;
            delay_q     <= '0;
            ld_q        <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          set_q   <= 1'b1;
          state_q <= ST_SET;
        end
        ST_SET: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settled) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (finished) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // Tap 0 has no predecessor, so havePrev keeps it from ever
          // being reported. The last tap ends the sweep instead of wrapping.
          if (havePrev_q && (maj != prevMaj_q)) begin
            edgeFound_q <= 1'b1;
            edgeTap_q   <= tap_q;
            edgePol_q   <= maj;
            delay_q     <= tap_q;
            ld_q        <= 1'b1;
            state_q     <= ST_APPLY;
          end else if (tap_q == TAP_MAX) begin
            edgeFound_q <= 1'b0;
            edgeTap_q   <= '0;
            edgePol_q   <= 1'b0;
            delay_q     <= '0;
            ld_q        <= 1'b1;
            state_q     <= ST_APPLY;
          end else begin
            prevMaj_q  <= maj;
            havePrev_q <= 1'b1;
            tap_q      <= tap_q + DLY_WIDTH'(1);
            delay_q    <= tap_q + DLY_WIDTH'(1);
            ld_q       <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_APPLY: begin
          set_q   <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign delay      = delay_q;
  assign ld         = ld_q;
  assign set        = set_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign edge_found = edgeFound_q;
  assign edge_tap   = edgeTap_q;
  assign edge_pol   = edgePol_q;

endmodule

// File: tb/tb_dqs_idelay_scan.sv
// ---------------------------------------------------------------------------
// tb_dqs_idelay_scan
// Self-checking bench for dqs_idelay_scan. A lane model drives dqs_sample
// from a per-tap table of 16-bit sample masks, indexed by the tap most
// recently applied with set and by the position inside the sample window.
// Outside the window it drives random noise. Expected results come from a
// tap-by-tap majority vote over the same table.
// ---------------------------------------------------------------------------
module tb_dqs_idelay_scan;

  localparam int SETTLE  = 8;
  localparam int NSAMP   = 16;
  localparam int NTAPS   = 32;
  localparam int PER_TAP = 3 + SETTLE + NSAMP;
  localparam int FULL    = NTAPS * PER_TAP + 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dqsSample;
  logic [4:0] delay;
  logic       ld;
  logic       set;
  logic       busy;
  logic       done;
  logic       edgeFound;
  logic [4:0] edgeTap;
  logic       edgePol;

  int checks;
  int errors;

  logic [15:0] tapMask [NTAPS];
  int          appliedTap;
  int          sinceSet;
  int          ldCount;

  dqs_idelay_scan dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dqs_sample (dqsSample),
    .delay      (delay),
    .ld         (ld),
    .set        (set),
    .busy       (busy),
    .done       (done),
    .edge_found (edgeFound),
    .edge_tap   (edgeTap),
    .edge_pol   (edgePol)
  );

  // Free-running scan clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane model: latches the applied tap on set, counts cycles since set and
  // presents the table bit for that tap during the sample window. Also
  // counts ld pulses for the current scan.
  initial begin
    logic [15:0] m;
    dqsSample  = 1'b0;
    appliedTap = 0;
    sinceSet   = 1000;
    ldCount    = 0;
    forever begin
      @(negedge clk);
      if (ld) ldCount++;
      if (set) begin
        appliedTap = int'(delay);
        sinceSet   = 0;
      end else if (sinceSet < 1000) begin
        sinceSet++;
      end
      if (sinceSet >= SETTLE + 1 && sinceSet < SETTLE + 1 + NSAMP) begin
        m         = tapMask[appliedTap];
        dqsSample = m[sinceSet - SETTLE - 1];
      end else begin
        dqsSample = 1'($urandom_range(1, 0));
      end
    end
  end

  // One counted comparison; reports and counts a failure.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Random 16-bit mask with exactly k ones.
  function automatic logic [15:0] maskWithOnes(input int k);
    logic [15:0] m;
    m = '0;
    while ($countones(m) < k) m[$urandom_range(15, 0)] = 1'b1;
    return m;
  endfunction

  // Reference: majority per tap (ties vote 0), first tap >= 1 whose vote
  // differs from the previous tap's. stopTap is the last tap swept.
  task automatic computeExpected(output int found, output int etap, output int pol,
                                 output int stopTap, output int cyc);
    int majPrev;
    int majNow;
    found   = 0;
    etap    = 0;
    pol     = 0;
    stopTap = NTAPS - 1;
    majPrev = ($countones(tapMask[0]) > NSAMP / 2) ? 1 : 0;
    for (int t = 1; t < NTAPS; t++) begin
      majNow = ($countones(tapMask[t]) > NSAMP / 2) ? 1 : 0;
      if (majNow != majPrev) begin
        found   = 1;
        etap    = t;
        pol     = majNow;
        stopTap = t;
        break;
      end
      majPrev = majNow;
    end
    cyc = (stopTap + 1) * PER_TAP + 2;
  endtask

  // Table where taps >= edgeT carry vote pol and the others carry !pol,
  // each with a random but unambiguous count (ties land on the 0 side).
  task automatic fillStep(input int edgeT, input int pol);
    int v;
    for (int t = 0; t < NTAPS; t++) begin
      v = (t >= edgeT) ? pol : 1 - pol;
      tapMask[t] = v ? maskWithOnes($urandom_range(16, 9)) : maskWithOnes($urandom_range(8, 0));
    end
  endtask

  // Run one scan. pulseAt >= 0 re-pulses start at that cycle; resetAt >= 0
  // pulses rst at that cycle and checks the abort instead of the result.
  // Cycle 1 is the first cycle after the edge that accepted start.
  task automatic applyStimulus(input string name, input int pulseAt, input int resetAt);
    int cycles;
    int expFound, expTap, expPol, expStop, expCycles;
    computeExpected(expFound, expTap, expPol, expStop, expCycles);
    @(negedge clk);
    ldCount = 0;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    checkOutput({name, ".busyAfterStart"}, busy, 1);
    checkOutput({name, ".edgeCleared"}, edgeFound, 0);
    while (!done && cycles < FULL + 100) begin
      @(negedge clk);
      cycles++;
      start = (cycles == pulseAt) ? 1'b1 : 1'b0;
      if (resetAt >= 0 && cycles == resetAt) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput({name, ".rstDelay"}, delay, 0);
        checkOutput({name, ".rstLd"}, ld, 0);
        checkOutput({name, ".rstSet"}, set, 0);
        checkOutput({name, ".rstBusy"}, busy, 0);
        checkOutput({name, ".rstDone"}, done, 0);
        checkOutput({name, ".rstEdgeFound"}, edgeFound, 0);
        checkOutput({name, ".rstEdgeTap"}, edgeTap, 0);
        checkOutput({name, ".rstEdgePol"}, edgePol, 0);
        @(negedge clk);
        checkOutput({name, ".rstNextLd"}, ld, 0);
        checkOutput({name, ".rstNextSet"}, set, 0);
        checkOutput({name, ".rstNextBusy"}, busy, 0);
        return;
      end
    end
    start = 1'b0;
    checkOutput({name, ".doneSeen"}, done, 1);
    checkOutput({name, ".cycles"}, cycles, expCycles);
    checkOutput({name, ".edgeFound"}, edgeFound, expFound);
    checkOutput({name, ".edgeTap"}, edgeTap, expTap);
    checkOutput({name, ".edgePol"}, edgePol, expPol);
    checkOutput({name, ".finalDelay"}, delay, expTap);
    checkOutput({name, ".finalSet"}, set, 1);
    checkOutput({name, ".busyAtDone"}, busy, 1);
    @(negedge clk);
    checkOutput({name, ".busyDropped"}, busy, 0);
    checkOutput({name, ".donePulse"}, done, 0);
    checkOutput({name, ".ldCount"}, ldCount, expStop + 2);
    checkOutput({name, ".appliedTap"}, appliedTap, expTap);
    checkOutput({name, ".edgeHeld"}, edgeTap, expTap);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int t = 0; t < NTAPS; t++) tapMask[t] = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset.delay", delay, 0);
    checkOutput("reset.ld", ld, 0);
    checkOutput("reset.set", set, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.edgeFound", edgeFound, 0);
    checkOutput("reset.edgeTap", edgeTap, 0);
    checkOutput("reset.edgePol", edgePol, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] step at tap 13");
    for (int t = 0; t < NTAPS; t++) tapMask[t] = (t >= 13) ? 16'hFFFF : 16'h0000;
    applyStimulus("step13", -1, -1);

    $display("[TB] constant zero, full sweep");
    for (int t = 0; t < NTAPS; t++) tapMask[t] = 16'h0000;
    applyStimulus("const0", -1, -1);

    $display("[TB] inverted step at tap 20");
    for (int t = 0; t < NTAPS; t++) tapMask[t] = (t < 20) ? 16'hFFFF : 16'h0000;
    applyStimulus("inv20", -1, -1);

    $display("[TB] tie at tap 7, bare majority at tap 8");
    for (int t = 0; t < NTAPS; t++) tapMask[t] = 16'h0000;
    tapMask[7] = maskWithOnes(8);
    tapMask[8] = maskWithOnes(9);
    applyStimulus("tie", -1, -1);

    $display("[TB] start pulsed during tap 4 sampling");
    for (int t = 0; t < NTAPS; t++) tapMask[t] = (t >= 13) ? 16'hFFFF : 16'h0000;
    applyStimulus("restartIgnored", 4 * PER_TAP + 17, -1);

    $display("[TB] reset during tap 10 settle, then fresh scan");
    applyStimulus("abort", -1, 10 * PER_TAP + 6);
    applyStimulus("afterAbort", -1, -1);

    $display("[TB] randomized step tables");
    for (int i = 0; i < 4; i++) begin
      fillStep($urandom_range(31, 1), $urandom_range(1, 0));
      applyStimulus($sformatf("randStep%0d", i), -1, -1);
    end

    $display("[TB] fully random vote tables");
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < NTAPS; t++) tapMask[t] = maskWithOnes($urandom_range(16, 0));
      applyStimulus($sformatf("randAny%0d", i), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
